psum_regfile: RTL and testbench
===============================

# psum_regfile

Partial-sum register file that serves as the responder on the MAC accumulate port: it returns the stored psum combinationally on the request address and commits the MAC result at the clock edge, giving a single-cycle read-modify-write. It also contains a sequencer that zeroes all entries after reset or on request, and a drain port that streams the finished layer's psums to the host with a valid/ready handshake. It sits between the MAC pipeline and the output/writeback logic.

## Interface
- DEPTH, 100, number of valid psum entries (addresses 0..DEPTH-1)
- AW, 7, address width
- DW, 16, data width (signed two's complement)

- clk  in  1  sole clock, all state on rising edge
- reset  in  1  asynchronous, active-high; one clock, asynchronous active-high reset
- mac_req_addr  in  AW  MAC port address (read and write share it)
- read  in  1  MAC read enable
- write  in  1  MAC write enable
- mac_out  in  DW  MAC write data
- reg_read  out  DW  MAC read data (combinational)
- clear_start  in  1  pulse: zero all entries
- drain_start  in  1  pulse: stream all entries out
- busy  out  1  high in CLEAR or DRAIN
- drain_valid  out  1  drain beat valid
- drain_ready  in  1  host accepts beat
- drain_addr  out  AW  index of current beat
- drain_data  out  DW  psum of current beat
- drain_last  out  1  high on beat DEPTH-1
- addr_err  out  1  sticky: MAC access with address >= DEPTH
- wr_drop  out  1  sticky: MAC write attempted while busy

## Operation
- FSM states: IDLE, CLEAR, DRAIN. Reset state is CLEAR, pointer 0.
- IDLE: MAC port live. reg_read = mem[mac_req_addr] when read=1 and address < DEPTH, else 0. write=1 with address < DEPTH stores mac_out at the edge. Both set on the same cycle is the normal accumulate case; reg_read shows the old value and the new value appears the next cycle.
- IDLE -> CLEAR on clear_start; IDLE -> DRAIN on drain_start. Both in the same cycle: CLEAR wins and drain_start is discarded.
- CLEAR: write 0 to mem[ptr] each cycle and increment ptr. At ptr == DEPTH-1, write it and return to IDLE with ptr = 0. This takes exactly DEPTH cycles.
- DRAIN: drain_valid = 1, drain_addr = ptr, drain_data = mem[ptr], drain_last = (ptr == DEPTH-1). On valid&&ready, increment ptr. On a last-beat handshake, return to IDLE with ptr = 0. drain_data/drain_addr stay stable while ready = 0.
- While busy: MAC writes are not performed and set wr_drop. MAC reads still return data; in CLEAR that may be a partly zeroed value.
- clear_start and drain_start while busy are ignored.
- Address >= DEPTH (100..127): reads return 0, writes are dropped, and addr_err is set. The check applies whenever read or write is high, in any state.
- addr_err and wr_drop clear only on reset.
- No arithmetic is done here; data is stored bit-exact, with no saturation.

## Timing
- Reset values: busy = 1 (CLEAR), drain_valid = 0, drain_last = 0, drain_addr = 0, addr_err = 0, wr_drop = 0. reg_read follows its combinational rule. Memory contents are not reset; the CLEAR pass that starts when reset releases defines them.
- Reset asserted mid-CLEAR or mid-DRAIN: abort immediately; the FSM restarts CLEAR from 0 on release.
- MAC read latency is 0 cycles, write latency 1 edge. There is no read-during-write bypass: same-cycle read returns the pre-write value.
- busy falls on the cycle after the final clear write or the final drain handshake. A start pulse in that IDLE cycle is accepted.
- A full drain with drain_ready held at 1 takes exactly DEPTH cycles.

## Structure
- Package psum_pkg holds DEPTH, AW and DW defaults and the state encoding (IDLE/CLEAR/DRAIN).
- Sub-module psum_ram is the DEPTH x DW array with:
  - one synchronous write port;
  - two asynchronous read ports (MAC and drain).
- The top level muxes the write port: CLEAR sequencer or MAC.

## Test plan
- Reset release -> busy stays 1 for 100 cycles then drops. A following drain returns 100 beats of 0 with drain_last only on addr 99.
- IDLE, read=write=1, addr 5, mac_out = reg_read + 3, repeated 4 cycles from 0 -> reg_read reads 0, 3, 6, 9. A drain shows entry 5 = 12.
- Write -32768 to addr 99 and 32767 to addr 0, then drain with drain_ready toggling 1/0 -> beats are held while ready = 0, values are bit-exact, and the drain finishes after 100 handshakes.
- MAC write to addr 120 -> reg_read = 0, addr_err = 1, memory unchanged. Reset clears addr_err.
- clear_start and drain_start in the same IDLE cycle -> CLEAR runs and no drain_valid appears. A MAC write during CLEAR sets wr_drop and the entry reads 0 afterwards.
- Assert reset at drain beat 50 -> drain_valid = 0 at once, and busy = 1 (CLEAR) after release.

Source files
------------

// File: rtl/psum_pkg.sv
// psum_pkg
//   Shared constants and the sequencer state encoding for the partial-sum
//   register file.
//   DEPTH    : number of valid psum entries (addresses 0..DEPTH-1)
//   AW / DW  : address width / signed data width
//   MAX_ADDR : highest valid address, pre-sized to AW bits for comparisons
//   state_t  : IDLE (MAC port live), CLEAR (zeroing pass), DRAIN (host stream)
package psum_pkg;

  localparam int DEPTH = 100;
  localparam int AW    = 7;
  localparam int DW    = 16;

  localparam logic [AW-1:0] MAX_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/psum_regfile_if.sv
// psum_regfile_if
//   Bundles the MAC accumulate port, the control pulses, the drain stream and
//   the sticky error flags of psum_regfile.
//   master : driven by the MAC pipeline / host side (requests, data, ready)
//   slave  : driven by psum_regfile (read data, busy, drain beat, flags)
interface psum_regfile_if;
  import psum_pkg::*;

  // MAC accumulate port
  logic [AW-1:0] mac_req_addr;
  logic          read;
  logic          write;
  logic [DW-1:0] mac_out;
  logic [DW-1:0] reg_read;

  // Sequencer control
  logic          clear_start;
  logic          drain_start;
  logic          busy;

  // Drain stream
  logic          drain_valid;
  logic          drain_ready;
  logic [AW-1:0] drain_addr;
  logic [DW-1:0] drain_data;
  logic          drain_last;

  // Sticky status
  logic          addr_err;
  logic          wr_drop;

  modport master (
    output mac_req_addr, read, write, mac_out,
    output clear_start, drain_start, drain_ready,
    input  reg_read, busy, drain_valid, drain_addr, drain_data, drain_last,
    input  addr_err, wr_drop
  );

  modport slave (
    input  mac_req_addr, read, write, mac_out,
    input  clear_start, drain_start, drain_ready,
    output reg_read, busy, drain_valid, drain_addr, drain_data, drain_last,
    output addr_err, wr_drop
  );

endinterface

// File: rtl/psum_ram.sv
// psum_ram
//   DEPTH x DW storage with one synchronous write port and two asynchronous
//   read ports.
//   clk                  : write clock
//   i_we/i_waddr/i_wdata : write port (caller guarantees i_waddr < DEPTH)
//   i_raddr_a/o_rdata_a  : asynchronous read port A (MAC side)
//   i_raddr_b/o_rdata_b  : asynchronous read port B (drain side)
//   Out-of-range read addresses return 0.
module psum_ram
  import psum_pkg::*;
(
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output logic [DW-1:0] o_rdata_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_b
);

  logic [DW-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset; the CLEAR pass that follows every reset
  // defines its contents, and a reset branch would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a <= MAX_ADDR) ? r_mem[i_raddr_a] : '0;
  assign o_rdata_b = (i_raddr_b <= MAX_ADDR) ? r_mem[i_raddr_b] : '0;

endmodule

// File: rtl/psum_regfile.sv
// psum_regfile
//   Partial-sum register file answering the MAC accumulate port (0-cycle
//   read, 1-edge write, no bypass), with a sequencer that zeroes every entry
//   after reset or on clear_start and streams all entries out on drain_start.
//   clk   : sole clock
//   reset : asynchronous, active-high; restarts the CLEAR pass from entry 0
//   bus   : psum_regfile_if.slave (MAC port, start pulses, drain stream,
//           busy, sticky addr_err / wr_drop)
module psum_regfile
  import psum_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  psum_regfile_if.slave  bus
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_nxt;

  logic          w_mac_addr_ok;
  logic          w_ptr_last;
  logic          w_mac_rd_access;

  logic          w_ram_we;
  logic [AW-1:0] w_ram_waddr;
  logic [DW-1:0] w_ram_wdata;
  logic [DW-1:0] w_mac_rdata;
  logic [DW-1:0] w_drain_rdata;

  logic          r_addr_err;
  logic          r_wr_drop;

  assign w_mac_addr_ok   = (bus.mac_req_addr <= MAX_ADDR);
  assign w_ptr_last      = (r_ptr == MAX_ADDR);
  assign w_mac_rd_access = bus.read && w_mac_addr_ok;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours; blocking here would create races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    unique case (r_state)
      IDLE: begin
        w_ptr_nxt = '0;
        // A simultaneous drain request is dropped in favour of the clear.
        if (bus.clear_start) begin
          w_state_nxt = CLEAR;
        end else if (bus.drain_start) begin
          w_state_nxt = DRAIN;
        end
      end
      CLEAR: begin
        if (w_ptr_last) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      DRAIN: begin
        if (bus.drain_ready) begin
          if (w_ptr_last) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = '0;
          end else begin
            w_ptr_nxt = r_ptr + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: write-port mux, drain beat, status
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ram_we        = 1'b0;
    w_ram_waddr     = bus.mac_req_addr;
    w_ram_wdata     = bus.mac_out;
    bus.busy        = 1'b1;
    bus.drain_valid = 1'b0;
    bus.drain_addr  = '0;
    bus.drain_data  = '0;
    bus.drain_last  = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus.busy = 1'b0;
        w_ram_we = bus.write && w_mac_addr_ok;
      end
      CLEAR: begin
        // The sequencer owns the write port; MAC writes are dropped.
        w_ram_we    = 1'b1;
        w_ram_waddr = r_ptr;
        w_ram_wdata = '0;
      end
      DRAIN: begin
        bus.drain_valid = 1'b1;
        bus.drain_addr  = r_ptr;
        bus.drain_data  = w_drain_rdata;
        bus.drain_last  = w_ptr_last;
      end
      default: begin
        bus.busy = 1'b1;
      end
    endcase
  end

  // Reads stay live in every state; out-of-range or idle reads return 0.
  assign bus.reg_read = w_mac_rd_access ? w_mac_rdata : '0;

  // ---------------------------------------------------------------------------
  // Sticky error flags, cleared only by reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr_err <= 1'b0;
      r_wr_drop  <= 1'b0;
    end else begin
      if ((bus.read || bus.write) && !w_mac_addr_ok) begin
        r_addr_err <= 1'b1;
      end
      if (bus.write && (r_state != IDLE)) begin
        r_wr_drop <= 1'b1;
      end
    end
  end

  assign bus.addr_err = r_addr_err;
  assign bus.wr_drop  = r_wr_drop;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  psum_ram u_ram (
    .clk       (clk),
    .i_we      (w_ram_we),
    .i_waddr   (w_ram_waddr),
    .i_wdata   (w_ram_wdata),
    .i_raddr_a (bus.mac_req_addr),
    .o_rdata_a (w_mac_rdata),
    .i_raddr_b (r_ptr),
    .o_rdata_b (w_drain_rdata)
  );

endmodule

// File: tb/tb_psum_regfile.sv
// tb_psum_regfile
//   Self-checking bench for psum_regfile. A plain array holds the expected
//   psum contents; busy periods, drain beats and sticky flags are predicted
//   from the block's behavioural rules. Inputs change just after the falling
//   edge and outputs are sampled 1 ns later, well away from the rising edge.
module tb_psum_regfile;
  import psum_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  psum_regfile_if bus ();

  psum_regfile dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] model_mem [DEPTH];
  logic          m_addr_err = 1'b0;
  logic          m_wr_drop  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.mac_req_addr = '0;
    bus.read         = 1'b0;
    bus.write        = 1'b0;
    bus.mac_out      = '0;
    bus.clear_start  = 1'b0;
    bus.drain_start  = 1'b0;
    bus.drain_ready  = 1'b0;
  endtask

  // Called on the falling edge before the first clear write. Counts cycles
  // until busy drops, and every entry is zero afterwards.
  task automatic wait_clear(input string tag);
    int cnt = 0;
    while (bus.busy && cnt < 200) begin
      check({tag, "_no_valid"}, 32'(bus.drain_valid), 32'd0);
      @(negedge clk);
      cnt++;
    end
    check({tag, "_cycles"}, 32'(cnt), 32'(DEPTH));
    foreach (model_mem[i]) model_mem[i] = '0;
  endtask

  // One MAC-port cycle in IDLE: check the combinational read, then the flags.
  task automatic mac_cycle(input logic [AW-1:0] a, input logic rd, input logic wr,
                           input logic [DW-1:0] d);
    logic [DW-1:0] exp;
    logic          in_range;
    @(negedge clk);
    bus.mac_req_addr = a;
    bus.read         = rd;
    bus.write        = wr;
    bus.mac_out      = d;
    in_range = (int'(a) < DEPTH);
    exp = (rd && in_range) ? model_mem[a] : '0;
    #1;
    check("reg_read", 32'(bus.reg_read), 32'(exp));
    @(posedge clk);
    if (wr && in_range) model_mem[a] = d;
    if ((rd || wr) && !in_range) m_addr_err = 1'b1;
    #1;
    check("addr_err", 32'(bus.addr_err), 32'(m_addr_err));
    check("wr_drop", 32'(bus.wr_drop), 32'(m_wr_drop));
  endtask

  // mode 0: ready held high, 1: ready toggles 1/0, 2: random ready.
  // start_now issues drain_start on the current falling edge (the IDLE cycle
  // in which a previous operation just finished).
  task automatic run_drain(input int mode, input bit start_now);
    int idx = 0;
    int cyc = 0;
    if (!start_now) @(negedge clk);
    idle_inputs();
    bus.drain_start = 1'b1;
    @(negedge clk);
    bus.drain_start = 1'b0;
    while (idx < DEPTH && cyc < 1000) begin
      case (mode)
        0:       bus.drain_ready = 1'b1;
        1:       bus.drain_ready = (cyc % 2 == 0);
        default: bus.drain_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      check("drain_valid", 32'(bus.drain_valid), 32'd1);
      check("drain_addr", 32'(bus.drain_addr), 32'(idx));
      check("drain_data", 32'(bus.drain_data), 32'(model_mem[idx]));
      check("drain_last", 32'(bus.drain_last), 32'(idx == DEPTH - 1));
      if (bus.drain_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    bus.drain_ready = 1'b0;
    #1;
    check("drain_beats", 32'(idx), 32'(DEPTH));
    if (mode == 0) check("drain_cycles", 32'(cyc), 32'(DEPTH));
    check("drain_done_busy", 32'(bus.busy), 32'd0);
    check("drain_done_valid", 32'(bus.drain_valid), 32'd0);
  endtask

  initial begin
    int cnt;
    idle_inputs();
    reset = 1'b1;
    #12;
    // Reset values
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_valid", 32'(bus.drain_valid), 32'd0);
    check("rst_last", 32'(bus.drain_last), 32'd0);
    check("rst_daddr", 32'(bus.drain_addr), 32'd0);
    check("rst_addr_err", 32'(bus.addr_err), 32'd0);
    check("rst_wr_drop", 32'(bus.wr_drop), 32'd0);
    check("rst_reg_read", 32'(bus.reg_read), 32'd0);

    // Initial clear pass after reset release, then an all-zero drain
    @(negedge clk);
    reset = 1'b0;
    wait_clear("init_clear");
    run_drain(0, 1'b1);

    // Single-cycle read-modify-write accumulate on entry 5
    for (int k = 0; k < 4; k++) begin
      mac_cycle(AW'(5), 1'b1, 1'b1, model_mem[5] + 16'd3);
    end
    check("acc_final", 32'(model_mem[5]), 32'd12);

    // Extremes, then a drain with ready toggling
    mac_cycle(AW'(99), 1'b0, 1'b1, 16'h8000);
    mac_cycle(AW'(0), 1'b0, 1'b1, 16'h7fff);
    mac_cycle(AW'(99), 1'b1, 1'b0, 16'h0000);
    run_drain(1, 1'b0);
    // A drain started in the IDLE cycle right after the previous one ends
    run_drain(2, 1'b1);

    // Out-of-range write must leave memory untouched and set addr_err
    mac_cycle(AW'(120), 1'b1, 1'b1, 16'hbeef);
    check("oor_flag", 32'(bus.addr_err), 32'd1);

    // Random MAC traffic, then confirm storage by a random-ready drain
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(100, 127))
                                      : AW'($urandom_range(0, DEPTH - 1));
      mac_cycle(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom));
    end
    run_drain(2, 1'b0);

    // Reset clears the sticky flag and restarts the clear pass
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    m_addr_err = 1'b0;
    m_wr_drop  = 1'b0;
    check("reset_addr_err", 32'(bus.addr_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_clear("reclear");

    // Populate a few entries so the next clear has something to erase
    for (int k = 0; k < 8; k++) begin
      mac_cycle(AW'(k * 7), 1'b0, 1'b1, DW'($urandom) | 16'h0001);
    end

    // Simultaneous clear_start/drain_start: clear wins; write during clear drops
    @(negedge clk);
    idle_inputs();
    bus.clear_start = 1'b1;
    bus.drain_start = 1'b1;
    @(negedge clk);
    bus.clear_start = 1'b0;
    bus.drain_start = 1'b0;
    cnt = 0;
    while (bus.busy && cnt < 200) begin
      #1;
      check("cs_no_valid", 32'(bus.drain_valid), 32'd0);
      if (cnt == 10) begin
        bus.mac_req_addr = AW'(2);
        bus.write        = 1'b1;
        bus.mac_out      = 16'h1234;
      end else begin
        bus.write = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    bus.write = 1'b0;
    check("cs_cycles", 32'(cnt), 32'(DEPTH));
    foreach (model_mem[i]) model_mem[i] = '0;
    m_wr_drop = 1'b1;
    #1;
    check("cs_wr_drop", 32'(bus.wr_drop), 32'(m_wr_drop));
    mac_cycle(AW'(2), 1'b1, 1'b0, 16'h0000);
    mac_cycle(AW'(14), 1'b1, 1'b0, 16'h0000);

    // Reset at drain beat 50 aborts immediately
    mac_cycle(AW'(60), 1'b0, 1'b1, 16'h5a5a);
    @(negedge clk);
    idle_inputs();
    bus.drain_start = 1'b1;
    @(negedge clk);
    bus.drain_start = 1'b0;
    bus.drain_ready = 1'b1;
    cnt = 0;
    while (cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    #1;
    check("pre_abort_addr", 32'(bus.drain_addr), 32'd50);
    reset = 1'b1;
    #1;
    check("abort_valid", 32'(bus.drain_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd1);
    check("abort_wr_drop", 32'(bus.wr_drop), 32'd0);
    m_wr_drop = 1'b0;
    @(negedge clk);
    bus.drain_ready = 1'b0;
    reset = 1'b0;
    #1;
    check("abort_busy_rel", 32'(bus.busy), 32'd1);
    wait_clear("abort_clear");
    run_drain(0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
